// File: rtl/skewed_mask_pkg.sv
// Shared pipelined-math helpers: chunk counts and chunk bit bounds for skewed datapaths.
package skewed_mask_pkg;

  function automatic int unsigned ceil_division(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  function automatic int unsigned chunk_lo(input int unsigned idx, input int unsigned chunk);
    return idx * chunk;
  endfunction

  // The last chunk is truncated to the word width.
  function automatic int unsigned chunk_hi(input int unsigned idx, input int unsigned chunk,
                                           input int unsigned width);
    return min_u(idx * chunk + chunk, width) - 1;
  endfunction

endpackage

// File: rtl/skewed_mask_delay.sv
// Enabled register chain of DELAY stages, synchronous active-low reset to zero.
module skewed_mask_delay #(
  parameter int unsigned DELAY = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DELAY == 0) begin : g_pass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_ni, en_i};
    assign q_o = d_i;
  end else begin : g_chain
    logic [WIDTH-1:0] stage_q [DELAY];
    logic [WIDTH-1:0] stage_d [DELAY];

    always_comb begin
      stage_d[0] = d_i;
      for (int k = 1; k < int'(DELAY); k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end

    // Reset wins over enable so the history is cleared even while stalled.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        for (int k = 0; k < int'(DELAY); k++) begin
          stage_q[k] <= '0;
        end
      end else if (en_i) begin
        stage_q <= stage_d;
      end
    end

    assign q_o = stage_q[DELAY-1];
  end

endmodule

// File: rtl/skewed_mask.sv
// Zeroes a chunk-skewed data word; the mask bit travels with chunk i via an i-deep history.
module skewed_mask
  import skewed_mask_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  input  logic             in_mask,
  output logic [WIDTH-1:0] out
);

  localparam int unsigned N = ceil_division(WIDTH, CHUNK);

  // m_tap[i] is the mask of the word whose chunk i is on `in` this cycle.
  logic [N-1:0] m_tap;

  assign m_tap[0] = in_mask;

  if (N == 1) begin : g_no_hist
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, en};
  end else begin : g_hist
    for (genvar i = 1; i < int'(N); i++) begin : g_stage
      skewed_mask_delay #(
        .DELAY(1),
        .WIDTH(1)
      ) u_stage (
        .clk_i (clk),
        .rst_ni(rst),
        .en_i  (en),
        .d_i   (m_tap[i-1]),
        .q_o   (m_tap[i])
      );
    end
  end

  for (genvar i = 0; i < int'(N); i++) begin : g_chunk
    localparam int unsigned LO = chunk_lo(i, CHUNK);
    localparam int unsigned HI = chunk_hi(i, CHUNK, WIDTH);
    localparam int unsigned CW = HI - LO + 1;

    assign out[HI:LO] = in[HI:LO] & {CW{m_tap[i]}};
  end

endmodule

// File: tb/tb_skewed_mask.sv
// Scoreboard bench for skewed_mask: three parameterisations driven together, plus skew round-trip.
module tb_skewed_mask;

  logic       clk;
  logic       rst;
  logic       en;
  logic       in_mask;
  logic [7:0] din;
  logic [4:0] din5;
  logic [7:0] out_a;
  logic [7:0] out_b;
  logic [4:0] out_c;

  assign din5 = din[4:0];

  skewed_mask #(.WIDTH(8), .CHUNK(3)) dut_a (
    .clk(clk), .rst(rst), .en(en), .in(din), .in_mask(in_mask), .out(out_a));
  skewed_mask #(.WIDTH(8), .CHUNK(8)) dut_b (
    .clk(clk), .rst(rst), .en(en), .in(din), .in_mask(in_mask), .out(out_b));
  skewed_mask #(.WIDTH(5), .CHUNK(2)) dut_c (
    .clk(clk), .rst(rst), .en(en), .in(din5), .in_mask(in_mask), .out(out_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] e_a;
    logic [7:0] e_b;
    logic [7:0] e_c;
    bit         has_lit;
    logic [7:0] lit;
    bit         has_e2e;
    logic [7:0] e2e;
    string      tag;
  } item_t;

  item_t sb_q[$];
  int    checks = 0;
  int    errors = 0;

  // hist[j]: mask given with in_mask j+1 enabled cycles ago (zero after reset).
  bit [1:0] hist = 2'b00;

  function automatic logic [7:0] model(input int w, input int c, input logic [7:0] d,
                                       input logic mk0, input bit [1:0] h);
    logic [7:0] r;
    r = 8'h00;
    for (int b = 0; b < w; b++) begin
      int  k;
      logic mk;
      k  = b / c;
      mk = (k == 0) ? mk0 : h[k-1];
      r[b] = d[b] & mk;
    end
    return r;
  endfunction

  task automatic step(input logic r, input logic e, input logic mk, input logic [7:0] d,
                      input bit hl, input logic [7:0] l, input bit he, input logic [7:0] ee,
                      input string tag);
    item_t it;
    @(negedge clk);
    rst     = r;
    en      = e;
    in_mask = mk;
    din     = d;
    it.e_a     = model(8, 3, d, mk, hist);
    it.e_b     = model(8, 8, d, mk, hist);
    it.e_c     = model(5, 2, {3'b000, d[4:0]}, mk, hist);
    it.has_lit = hl;
    it.lit     = l;
    it.has_e2e = he;
    it.e2e     = ee;
    it.tag     = tag;
    sb_q.push_back(it);
    @(posedge clk);
    if (!r) hist = 2'b00;
    else if (e) hist = {hist[0], mk};
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: out is combinational, so it is valid every cycle; sample mid low phase.
  logic [7:0] oh1 = 8'h00;
  logic [7:0] oh2 = 8'h00;

  always @(negedge clk) begin
    item_t      it;
    logic [7:0] unskew;
    #2;
    unskew = {out_a[7:6], oh1[5:3], oh2[2:0]};
    if (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      check({it.tag, "/w8c3"}, out_a, it.e_a);
      check({it.tag, "/w8c8"}, out_b, it.e_b);
      check({it.tag, "/w5c2"}, {3'b000, out_c}, it.e_c);
      if (it.has_lit) check({it.tag, "/lit"}, out_a, it.lit);
      if (it.has_e2e) check({it.tag, "/e2e"}, unskew, it.e2e);
    end
    oh2 = oh1;
    oh1 = out_a;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] w_arr [40];
  bit         m_arr [40];

  initial begin
    logic [7:0] d;
    logic [7:0] ee;
    rst = 1'b0; en = 1'b1; in_mask = 1'b0; din = 8'h00;

    // Reset with zero data: outputs are independent of pre-reset state.
    step(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, "rst0");
    step(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, "rst1");

    // History refill after reset.
    step(1, 1, 1, 8'hFF, 1, 8'h07, 0, 8'h00, "fill0");
    step(1, 1, 1, 8'hFF, 1, 8'h3F, 0, 8'h00, "fill1");
    step(1, 1, 1, 8'hFF, 1, 8'hFF, 0, 8'h00, "fill2");
    step(1, 1, 1, 8'hFF, 1, 8'hFF, 0, 8'h00, "fill3");

    // Mask sequence following the skew.
    step(1, 1, 1, 8'hFF, 1, 8'hFF, 0, 8'h00, "seq0");
    step(1, 1, 0, 8'hFF, 1, 8'hF8, 0, 8'h00, "seq1");
    step(1, 1, 1, 8'hFF, 1, 8'hC7, 0, 8'h00, "seq2");
    step(1, 1, 1, 8'hFF, 1, 8'h3F, 0, 8'h00, "seq3");
    step(1, 1, 0, 8'hFF, 1, 8'hF8, 0, 8'h00, "seq4");
    step(1, 1, 1, 8'hFF, 1, 8'hC7, 0, 8'h00, "seq5");

    // Frozen history m=[0,1,0].
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      step(1, 0, 0, d, 1, d & 8'h38, 0, 8'h00, "freeze");
    end

    // Reset mid-stream with en low: reset still clears the history.
    step(1, 1, 1, 8'hFF, 1, 8'h3F, 0, 8'h00, "pre0");
    step(1, 1, 1, 8'hFF, 1, 8'hFF, 0, 8'h00, "pre1");
    step(1, 1, 1, 8'hFF, 1, 8'hFF, 0, 8'h00, "pre2");
    step(0, 0, 1, 8'hFF, 1, 8'hFF, 0, 8'h00, "midrst");
    step(1, 1, 1, 8'hFF, 1, 8'h07, 0, 8'h00, "post0");
    step(1, 1, 1, 8'hFF, 1, 8'h3F, 0, 8'h00, "post1");
    step(1, 1, 1, 8'hFF, 1, 8'hFF, 0, 8'h00, "post2");

    // Random traffic with stalls and occasional resets.
    for (int i = 0; i < 300; i++) begin
      step(($urandom % 20) != 0, ($urandom % 4) != 0, 1'($urandom), 8'($urandom),
           0, 8'h00, 0, 8'h00, "rand");
    end

    // Round trip: skew words, mask, unskew, compare with the plainly masked word 2 cycles late.
    for (int t = 0; t < 40; t++) begin
      w_arr[t] = 8'($urandom);
      m_arr[t] = 1'($urandom);
    end
    for (int t = 0; t < 40; t++) begin
      d = 8'h00;
      for (int b = 0; b < 8; b++) begin
        if (t - b / 3 >= 0) d[b] = w_arr[t - b / 3][b];
      end
      ee = (t >= 2) ? (w_arr[t-2] & {8{m_arr[t-2]}}) : 8'h00;
      step(1, 1, m_arr[t], d, 0, 8'h00, t >= 2, ee, "e2e");
    end

    @(negedge clk);
    #5;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d items left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
